dac_frame_scheduler: RTL and testbench

//  Sequences the dual-channel 12-bit SPI DAC on the wavegen PMOD pins (CS, CLK, SDI, LDAC).

---
 rtl/dac_frame_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_dac_frame_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler
// Round-robin arbiter and SPI serializer for a dual-channel 12-bit DAC.
// Each grant sends one 16-bit frame {ch, 0, ~gain2x, SHDN_n, data}. LDAC is
// pulsed after every frame, or in sync mode only once both channels have been
// refreshed since the previous pulse.
`timescale 1ns/1ps

module dac_frame_scheduler #(
    parameter int CLK_DIV     = 5,
    parameter int CS_GAP      = 2,
    parameter int LDAC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sync_mode,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [11:0] a_data,
    input  logic        a_gain2x,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [11:0] b_data,
    input  logic        b_gain2x,
    output logic        busy,
    output logic        cs,
    output logic        sclk,
    output logic        sdi,
    output logic        ldac
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        LDAC  = 2'd3
    } state_t;

    // Terminal counts for the shared phase counter. A CS_GAP of zero still
    // yields one GAP cycle so the LDAC decision always has a state to live in.
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'((CS_GAP > 0) ? (CS_GAP - 1) : 0);
    localparam logic [15:0] LDAC_LAST = 16'(LDAC_CYCLES - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_cnt;
    logic [3:0]  r_bitCnt;
    logic [14:0] r_shift;
    logic        r_cs;
    logic        r_sclk;
    logic        r_sdi;
    logic        r_ldac;
    logic        r_pendA;
    logic        r_pendB;
    logic        r_lastB;

    logic        w_grantA;
    logic        w_grantB;
    logic        w_divEnd;
    logic        w_gapEnd;
    logic        w_ldacEnd;
    logic        w_lastFall;
    logic [15:0] w_frame;

    function automatic logic [15:0] buildFrame(input logic ch, input logic gain2x,
                                               input logic [11:0] data);
        return {ch, 1'b0, ~gain2x, 1'b1, data};
    endfunction

    // Grant is combinational in IDLE; on contention the channel that was not
    // served last wins.
    assign w_grantA = (r_state == IDLE) && a_valid && (!b_valid || r_lastB);
    assign w_grantB = (r_state == IDLE) && b_valid && !w_grantA;
    assign a_ready  = w_grantA;
    assign b_ready  = w_grantB;

    assign w_frame    = w_grantB ? buildFrame(1'b1, b_gain2x, b_data)
                                 : buildFrame(1'b0, a_gain2x, a_data);
    assign w_divEnd   = (r_cnt == DIV_LAST);
    assign w_gapEnd   = (r_cnt == GAP_LAST);
    assign w_ldacEnd  = (r_cnt == LDAC_LAST);
    assign w_lastFall = w_divEnd && r_sclk && (r_bitCnt == 4'd15);

    assign busy = (r_state != IDLE);
    assign cs   = r_cs;
    assign sclk = r_sclk;
    assign sdi  = r_sdi;
    assign ldac = r_ldac;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_nextState;
    end

    // Next-state decode; the sync_mode decision is taken only at the end of GAP.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (w_grantA || w_grantB) w_nextState = SHIFT;
            SHIFT: if (w_lastFall) w_nextState = GAP;
            GAP: begin
                if (w_gapEnd) begin
                    if (!sync_mode || (r_pendA && r_pendB)) w_nextState = LDAC;
                    else                                    w_nextState = IDLE;
                end
            end
            LDAC:  if (w_ldacEnd) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: frame load, SCLK generation, bit shifting, pending flags and
    // registered pin drivers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_cs     <= 1'b1;
            r_sclk   <= 1'b0;
            r_sdi    <= 1'b0;
            r_ldac   <= 1'b1;
            r_pendA  <= 1'b0;
            r_pendB  <= 1'b0;
            r_lastB  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt    <= '0;
                    r_bitCnt <= '0;
                    if (w_grantA || w_grantB) begin
                        r_shift <= w_frame[14:0];
                        r_sdi   <= w_frame[15];
                        r_cs    <= 1'b0;
                        r_lastB <= w_grantB;
                        if (w_grantB) r_pendB <= 1'b1;
                        else          r_pendA <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_divEnd) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        if (r_sclk) begin
                            if (r_bitCnt == 4'd15) begin
                                r_cs  <= 1'b1;
                                r_sdi <= 1'b0;
                            end else begin
                                r_bitCnt <= r_bitCnt + 4'd1;
                                r_sdi    <= r_shift[14];
                                r_shift  <= {r_shift[13:0], 1'b0};
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (w_gapEnd) begin
                        r_cnt <= '0;
                        if (w_nextState == LDAC) r_ldac <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                LDAC: begin
                    if (w_ldacEnd) begin
                        r_cnt   <= '0;
                        r_ldac  <= 1'b1;
                        r_pendA <= 1'b0;
                        r_pendB <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb_dac_frame_scheduler
// Directed bench: two scheduler instances (CLK_DIV=5 and CLK_DIV=1) share
// clock, reset, sync_mode and sample data; each has its own valid lines.
`timescale 1ns/1ps

module tb_dac_frame_scheduler;

    logic        clk;
    logic        resetn;
    logic        syncMode;
    logic [11:0] aData;
    logic [11:0] bData;
    logic        aGain;
    logic        bGain;
    logic        aValid0, bValid0, aValid1, bValid1;
    logic        aReady0, bReady0, aReady1, bReady1;
    logic        busy0, cs0, sclk0, sdi0, ldac0;
    logic        busy1, cs1, sclk1, sdi1, ldac1;

    int nChecks = 0;
    int nFails  = 0;

    dac_frame_scheduler #(.CLK_DIV(5), .CS_GAP(2), .LDAC_CYCLES(4)) dut0 (
        .clk(clk), .resetn(resetn), .sync_mode(syncMode),
        .a_valid(aValid0), .a_ready(aReady0), .a_data(aData), .a_gain2x(aGain),
        .b_valid(bValid0), .b_ready(bReady0), .b_data(bData), .b_gain2x(bGain),
        .busy(busy0), .cs(cs0), .sclk(sclk0), .sdi(sdi0), .ldac(ldac0)
    );

    dac_frame_scheduler #(.CLK_DIV(1), .CS_GAP(2), .LDAC_CYCLES(4)) dut1 (
        .clk(clk), .resetn(resetn), .sync_mode(syncMode),
        .a_valid(aValid1), .a_ready(aReady1), .a_data(aData), .a_gain2x(aGain),
        .b_valid(bValid1), .b_ready(bReady1), .b_data(bData), .b_gain2x(bGain),
        .busy(busy1), .cs(cs1), .sclk(sclk1), .sdi(sdi1), .ldac(ldac1)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic getCs(input int sel);   return sel ? cs1   : cs0;   endfunction
    function automatic logic getSclk(input int sel); return sel ? sclk1 : sclk0; endfunction
    function automatic logic getSdi(input int sel);  return sel ? sdi1  : sdi0;  endfunction
    function automatic logic getLdac(input int sel); return sel ? ldac1 : ldac0; endfunction
    function automatic logic getBusy(input int sel); return sel ? busy1 : busy0; endfunction
    function automatic logic getReady(input int sel, input int ch);
        if (sel == 0) return ch ? bReady0 : aReady0;
        return ch ? bReady1 : aReady1;
    endfunction

    task automatic setValid(input int sel, input int ch, input logic v);
        if (sel == 0) begin
            if (ch == 0) aValid0 = v; else bValid0 = v;
        end else begin
            if (ch == 0) aValid1 = v; else bValid1 = v;
        end
    endtask

    // Raise one request, wait (bounded) for its grant, complete the handshake
    // on the next rising edge and drop valid just after it.
    task automatic applyStimulus(input int sel, input int ch, input logic [11:0] data,
                                 input logic gain);
        int guard;
        @(negedge clk);
        if (ch == 0) begin aData = data; aGain = gain; end
        else         begin bData = data; bGain = gain; end
        setValid(sel, ch, 1'b1);
        #1;
        guard = 0;
        while (!getReady(sel, ch) && guard < 400) begin
            @(negedge clk); #1; guard++;
        end
        checkOutput("grant", getReady(sel, ch), 1'b1);
        @(posedge clk); #1;
        setValid(sel, ch, 1'b0);
    endtask

    // Follow one frame from CS falling until the block is idle again:
    // collects SDI on each SCLK rise, the CS-low length, GAP length and LDAC width.
    task automatic captureFrame(input int sel, output logic [15:0] frame, output int csLow,
                                output int rises, output int gap, output int ldacLen);
        int   guard;
        logic prevS;
        frame = '0; csLow = 0; rises = 0; gap = 0; ldacLen = 0; prevS = 1'b0;
        guard = 0;
        @(negedge clk);
        while (getCs(sel) !== 1'b0 && guard < 50) begin
            @(negedge clk); guard++;
        end
        checkOutput("csFall", getCs(sel), 1'b0);
        while (getCs(sel) === 1'b0 && csLow < 1000) begin
            csLow++;
            if (getSclk(sel) && !prevS) begin
                frame = {frame[14:0], getSdi(sel)};
                rises++;
            end
            prevS = getSclk(sel);
            @(negedge clk);
        end
        checkOutput("sclkIdle", getSclk(sel), 1'b0);
        checkOutput("sdiIdle", getSdi(sel), 1'b0);
        guard = 0;
        while (getBusy(sel) && guard < 100) begin
            if (!getLdac(sel))      ldacLen++;
            else if (ldacLen == 0)  gap++;
            @(negedge clk); guard++;
        end
        checkOutput("idleReturn", getBusy(sel), 1'b0);
    endtask

    // Wait (bounded) for whichever channel is granted while both request.
    task automatic waitEitherGrant(output int ch);
        int guard;
        guard = 0;
        #1;
        while (!aReady0 && !bReady0 && guard < 400) begin
            @(negedge clk); #1; guard++;
        end
        checkOutput("anyGrant", {31'd0, aReady0 | bReady0}, 32'd1);
        ch = bReady0 ? 1 : 0;
    endtask

    logic [15:0] frame;
    int csLow, rises, gap, ldacLen, ch;
    logic [15:0] expFrames [3];
    int          expCh     [3];

    initial begin
        resetn = 1'b0; syncMode = 1'b0;
        aData = '0; bData = '0; aGain = 1'b0; bGain = 1'b0;
        aValid0 = 0; bValid0 = 0; aValid1 = 0; bValid1 = 0;
        expFrames[0] = 16'h3ABC; expFrames[1] = 16'hB456; expFrames[2] = 16'h3ABC;
        expCh[0] = 0; expCh[1] = 1; expCh[2] = 0;

        // Reset state held with no requests.
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rstCs",   cs0,   1'b1);
            checkOutput("rstSclk", sclk0, 1'b0);
            checkOutput("rstSdi",  sdi0,  1'b0);
            checkOutput("rstLdac", ldac0, 1'b1);
            checkOutput("rstBusy", busy0, 1'b0);
            checkOutput("rstReady", {aReady0, bReady0}, 2'b00);
        end

        // Per-frame LDAC, A then B frame content and timing.
        applyStimulus(0, 0, 12'hABC, 1'b0);
        captureFrame(0, frame, csLow, rises, gap, ldacLen);
        checkOutput("aFrame", frame, 16'h3ABC);
        checkOutput("aRises", rises, 16);
        checkOutput("aCsLow", csLow, 160);
        checkOutput("aGap",   gap, 2);
        checkOutput("aLdac",  ldacLen, 4);
        applyStimulus(0, 1, 12'h123, 1'b1);
        captureFrame(0, frame, csLow, rises, gap, ldacLen);
        checkOutput("bFrame", frame, 16'h9123);
        checkOutput("bCsLow", csLow, 160);
        checkOutput("bLdac",  ldacLen, 4);

        // Both channels requesting continuously: grants alternate A, B, A.
        @(negedge clk);
        aData = 12'hABC; aGain = 1'b0; bData = 12'h456; bGain = 1'b0;
        aValid0 = 1'b1; bValid0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitEitherGrant(ch);
            checkOutput($sformatf("rrOrder%0d", i), ch, expCh[i]);
            @(posedge clk); #1;
            if (i == 2) begin aValid0 = 1'b0; bValid0 = 1'b0; end
            captureFrame(0, frame, csLow, rises, gap, ldacLen);
            checkOutput($sformatf("rrFrame%0d", i), frame, expFrames[i]);
        end

        // Sync mode: A alone no pulse, B completes the pair, A twice no pulse.
        syncMode = 1'b1;
        applyStimulus(0, 0, 12'h111, 1'b0);
        captureFrame(0, frame, csLow, rises, gap, ldacLen);
        checkOutput("syncAFrame", frame, 16'h3111);
        checkOutput("syncANoLdac", ldacLen, 0);
        applyStimulus(0, 1, 12'h222, 1'b0);
        captureFrame(0, frame, csLow, rises, gap, ldacLen);
        checkOutput("syncBFrame", frame, 16'hB222);
        checkOutput("syncBGap",  gap, 2);
        checkOutput("syncBLdac", ldacLen, 4);
        applyStimulus(0, 0, 12'h333, 1'b1);
        captureFrame(0, frame, csLow, rises, gap, ldacLen);
        checkOutput("syncA1NoLdac", ldacLen, 0);
        applyStimulus(0, 0, 12'h444, 1'b1);
        captureFrame(0, frame, csLow, rises, gap, ldacLen);
        checkOutput("syncA2Frame", frame, 16'h1444);
        checkOutput("syncA2NoLdac", ldacLen, 0);

        // Reset in the middle of a frame, then a clean frame afterwards.
        syncMode = 1'b0;
        applyStimulus(0, 0, 12'hFFF, 1'b1);
        repeat (50) @(negedge clk);
        checkOutput("midFrameCs", cs0, 1'b0);
        resetn = 1'b0;
        #1;
        checkOutput("midRstCs",   cs0,   1'b1);
        checkOutput("midRstSclk", sclk0, 1'b0);
        checkOutput("midRstBusy", busy0, 1'b0);
        checkOutput("midRstLdac", ldac0, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(0, 0, 12'h5C3, 1'b0);
        captureFrame(0, frame, csLow, rises, gap, ldacLen);
        checkOutput("postRstFrame", frame, 16'h35C3);
        checkOutput("postRstRises", rises, 16);
        checkOutput("postRstCsLow", csLow, 160);

        // Fastest serial clock on the CLK_DIV=1 instance.
        applyStimulus(1, 0, 12'h5A5, 1'b1);
        captureFrame(1, frame, csLow, rises, gap, ldacLen);
        checkOutput("div1AFrame", frame, 16'h15A5);
        checkOutput("div1ACsLow", csLow, 32);
        checkOutput("div1ARises", rises, 16);
        checkOutput("div1ALdac",  ldacLen, 4);
        applyStimulus(1, 1, 12'h0F0, 1'b0);
        captureFrame(1, frame, csLow, rises, gap, ldacLen);
        checkOutput("div1BFrame", frame, 16'hB0F0);
        checkOutput("div1BCsLow", csLow, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
